// File: rtl/drygascon_pkg.sv
// Shared types and default sizing for the DRYGASCON G-function sequencer.
// Holds the sequencer state encoding and a saturating counter helper.
package drygascon_pkg;

    localparam int DRYG_CWIDTH  = 320;
    localparam int DRYG_RWIDTH  = 128;
    localparam int DRYG_RCW     = 4;
    localparam int DRYG_TIMEOUT = 64;

    typedef enum logic [2:0] {
        G_IDLE      = 3'd0,
        G_PERM      = 3'd1,
        G_WAIT_PERM = 3'd2,
        G_ACC       = 3'd3,
        G_WAIT_ACC  = 3'd4,
        G_NEXT      = 3'd5,
        G_FIN       = 3'd6
    } g_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/drygascon_g_wdog.sv
// Engine watchdog: counts cycles spent waiting on an engine; expired fires on
// the TIMEOUT-th consecutive waiting cycle after the last clear.
module drygascon_g_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && !expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = run && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/drygascon_g_seq.sv
// DRYGASCON G-function sequencer: N x {round engine, accumulator} over external engines.
// Optional DRYG_CYCLE_COUNT_EN adds cyc_cnt (accepted start to done, saturating).
module drygascon_g_seq
    import drygascon_pkg::*;
#(
    parameter int CWIDTH  = DRYG_CWIDTH,
    parameter int RWIDTH  = DRYG_RWIDTH,
    parameter int RCW     = DRYG_RCW,
    parameter int TIMEOUT = DRYG_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CWIDTH-1:0] c_in,
    input  logic [RWIDTH-1:0] r_in,
    input  logic [RCW-1:0]    rounds,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [CWIDTH-1:0] c_out,
    output logic [RWIDTH-1:0] r_out,
    output logic              perm_start,
    output logic [RCW-1:0]    perm_round,
    output logic [CWIDTH-1:0] perm_c,
    input  logic [CWIDTH-1:0] perm_c_res,
    input  logic              perm_done,
    output logic              acc_start,
    output logic [CWIDTH-1:0] acc_c,
    output logic [RWIDTH-1:0] acc_r,
    input  logic [RWIDTH-1:0] acc_r_res,
    input  logic              acc_done
`ifdef DRYG_CYCLE_COUNT_EN
    ,
    output logic [15:0]       cyc_cnt
`endif
);

    g_state_t          r_state;
    g_state_t          w_state_next;
    logic [CWIDTH-1:0] r_c;
    logic [RWIDTH-1:0] r_r;
    logic [RCW-1:0]    r_n;
    logic [RCW:0]      r_j;
    logic              r_done;
    logic              r_err;
    logic [CWIDTH-1:0] r_c_out;
    logic [RWIDTH-1:0] r_r_out;

    logic              w_ready;
    logic              w_accept;
    logic              w_wait;
    logic              w_clear;
    logic              w_expired;
    logic              w_finish;
    logic [RCW:0]      w_j_inc;

    // Hold off a new start during the done cycle so ready rises the cycle after done.
    assign w_ready  = (r_state == G_IDLE) && !r_done;
    assign w_accept = start && w_ready;
    assign w_wait   = (r_state == G_WAIT_PERM) || (r_state == G_WAIT_ACC);
    assign w_clear  = (r_state == G_PERM) || (r_state == G_ACC);
    assign w_finish = (r_state == G_FIN) || w_expired;
    assign w_j_inc  = r_j + (RCW + 1)'(1);

    drygascon_g_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .run     (w_wait),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= G_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            G_IDLE: begin
                if (w_accept) begin
                    w_state_next = (rounds == '0) ? G_FIN : G_PERM;
                end
            end
            G_PERM:      w_state_next = G_WAIT_PERM;
            G_WAIT_PERM: begin
                if (w_expired) begin
                    w_state_next = G_IDLE;
                end else if (perm_done) begin
                    w_state_next = G_ACC;
                end
            end
            G_ACC:       w_state_next = G_WAIT_ACC;
            G_WAIT_ACC: begin
                if (w_expired) begin
                    w_state_next = G_IDLE;
                end else if (acc_done) begin
                    w_state_next = G_NEXT;
                end
            end
            G_NEXT: begin
                // Compared one bit wider so N = 2**RCW - 1 never wraps the index.
                w_state_next = (w_j_inc == {1'b0, r_n}) ? G_FIN : G_PERM;
            end
            G_FIN:       w_state_next = G_IDLE;
            default:     w_state_next = G_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c     <= '0;
            r_r     <= '0;
            r_n     <= '0;
            r_j     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_c_out <= '0;
            r_r_out <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_finish) begin
                r_done  <= 1'b1;
                r_err   <= w_expired;
                r_c_out <= r_c;
                r_r_out <= r_r;
            end
            case (r_state)
                G_IDLE: begin
                    if (w_accept) begin
                        r_c <= c_in;
                        r_r <= r_in;
                        r_n <= rounds;
                        r_j <= '0;
                    end
                end
                G_WAIT_PERM: begin
                    if (perm_done && !w_expired) begin
                        r_c <= perm_c_res;
                    end
                end
                G_WAIT_ACC: begin
                    if (acc_done && !w_expired) begin
                        r_r <= acc_r_res;
                    end
                end
                G_NEXT:  r_j <= w_j_inc;
                default: ;
            endcase
        end
    end

`ifdef DRYG_CYCLE_COUNT_EN
    logic [15:0] r_run;
    logic [15:0] r_cyc_cnt;

    // r_run counts the accept cycle as 1, so a zero-round job reports 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= '0;
            r_cyc_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_run <= 16'd1;
            end else if (r_state != G_IDLE) begin
                r_run <= sat_inc16(r_run);
            end
            if (w_finish) begin
                r_cyc_cnt <= sat_inc16(r_run);
            end
        end
    end

    assign cyc_cnt = r_cyc_cnt;
`endif

    assign ready      = w_ready;
    assign done       = r_done;
    assign err        = r_err;
    assign c_out      = r_c_out;
    assign r_out      = r_r_out;
    assign perm_start = (r_state == G_PERM);
    assign perm_round = r_j[RCW-1:0];
    assign perm_c     = r_c;
    assign acc_start  = (r_state == G_ACC);
    assign acc_c      = r_c;
    assign acc_r      = r_r;

endmodule

// File: tb/tb_drygascon_g_seq.sv
// Scoreboard bench for drygascon_g_seq with behavioural round/accumulator engines
// (round: c+1, accumulator: r ^ c[RW-1:0]).
module tb_drygascon_g_seq;

    localparam int CW = 320;
    localparam int RW = 128;
    localparam int NW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] c_in = '0;
    logic [RW-1:0] r_in = '0;
    logic [NW-1:0] rounds = '0;
    logic          ready, done, err;
    logic [CW-1:0] c_out;
    logic [RW-1:0] r_out;
    logic          perm_start;
    logic [NW-1:0] perm_round;
    logic [CW-1:0] perm_c;
    logic          perm_done_e = 1'b0;
    logic [CW-1:0] perm_res_e = '0;
    logic          acc_start;
    logic [CW-1:0] acc_c;
    logic [RW-1:0] acc_r;
    logic          acc_done_e = 1'b0;
    logic [RW-1:0] acc_res_e = '0;
    logic          spur_acc = 1'b0;
    logic          acc_done;
    logic [RW-1:0] acc_r_res;
`ifdef DRYG_CYCLE_COUNT_EN
    logic [15:0]   cyc_cnt;
`endif

    assign acc_done  = acc_done_e | spur_acc;
    assign acc_r_res = spur_acc ? {RW{1'b1}} : acc_res_e;

    always #5 clk = ~clk;

    drygascon_g_seq #(
        .CWIDTH (CW), .RWIDTH (RW), .RCW (NW), .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .c_in       (c_in),
        .r_in       (r_in),
        .rounds     (rounds),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .c_out      (c_out),
        .r_out      (r_out),
        .perm_start (perm_start),
        .perm_round (perm_round),
        .perm_c     (perm_c),
        .perm_c_res (perm_res_e),
        .perm_done  (perm_done_e),
        .acc_start  (acc_start),
        .acc_c      (acc_c),
        .acc_r      (acc_r),
        .acc_r_res  (acc_r_res),
        .acc_done   (acc_done)
`ifdef DRYG_CYCLE_COUNT_EN
        ,
        .cyc_cnt    (cyc_cnt)
`endif
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [RW-1:0] r;
        logic          e;
        int            done_cyc;
        int            perm_n;
        int            acc_n;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   job_id = 0;
    int   rst_epoch = 0;
    int   perm_dly = 0;
    int   acc_dly = 0;
    bit   rand_dly = 1'b0;
    bit   perm_mute = 1'b0;
    int   perm_cnt = 0;
    int   acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [CW-1:0] c0, input logic [RW-1:0] r0, input int n,
                                  output logic [CW-1:0] c1, output logic [RW-1:0] r1);
        c1 = c0;
        r1 = r0;
        for (int i = 0; i < n; i++) begin
            c1 = c1 + 1'b1;
            r1 = r1 ^ c1[RW-1:0];
        end
    endfunction

    // Round engine: responds d cycles after the one-cycle minimum, checks operand hold.
    always begin : perm_eng
        int            ep;
        int            d;
        logic [CW-1:0] cap;
        @(negedge clk);
        if (reset_n && perm_start && !perm_mute) begin
            ep  = rst_epoch;
            cap = perm_c;
            d   = rand_dly ? int'($urandom_range(0, 20)) : perm_dly;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                if (ep == rst_epoch) chk_vec("perm_c_stable", perm_c, cap);
            end
            @(posedge clk);
            #1;
            perm_done_e = 1'b1;
            perm_res_e  = cap + 1'b1;
            @(posedge clk);
            #1;
            perm_done_e = 1'b0;
        end
    end

    always begin : acc_eng
        int            ep;
        int            d;
        logic [CW-1:0] cap_c;
        logic [RW-1:0] cap_r;
        @(negedge clk);
        if (reset_n && acc_start) begin
            ep    = rst_epoch;
            cap_c = acc_c;
            cap_r = acc_r;
            d     = rand_dly ? int'($urandom_range(0, 20)) : acc_dly;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                if (ep == rst_epoch) begin
                    chk_vec("acc_c_stable", acc_c, cap_c);
                    chk_vec("acc_r_stable", {{(CW-RW){1'b0}}, acc_r}, {{(CW-RW){1'b0}}, cap_r});
                end
            end
            @(posedge clk);
            #1;
            acc_done_e = 1'b1;
            acc_res_e  = cap_r ^ cap_c[RW-1:0];
            @(posedge clk);
            #1;
            acc_done_e = 1'b0;
        end
    end

    // Engine pulse counters per job plus round-index check.
    always begin : pulse_watch
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (job_id != seen) begin
                seen     = job_id;
                perm_cnt = 0;
                acc_cnt  = 0;
            end
            if (reset_n && perm_start) begin
                chk_int("perm_round", int'(perm_round), perm_cnt);
                perm_cnt++;
            end
            if (reset_n && acc_start) acc_cnt++;
        end
    end

    always begin : monitor
        exp_t e;
        bit   ready_chk;
        ready_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_chk) begin
                chk_int("ready_after_done", int'(ready), 1);
                ready_chk = 1'b0;
            end
            if (reset_n && err && !done) chk_int("err_without_done", 1, 0);
            if (reset_n && done) begin
                if (sb_q.size() == 0) begin
                    chk_int("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk_vec("c_out", c_out, e.c);
                    chk_vec("r_out", {{(CW-RW){1'b0}}, r_out}, {{(CW-RW){1'b0}}, e.r});
                    chk_int("err", int'(err), int'(e.e));
                    if (e.done_cyc >= 0) chk_int("done_cycle", cyc, e.done_cyc);
                    chk_int("perm_pulses", perm_cnt, e.perm_n);
                    chk_int("acc_pulses", acc_cnt, e.acc_n);
                    ready_chk = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [CW-1:0] c, input logic [RW-1:0] r, input int n, output int acc_cyc);
        int k;
        k = 0;
        while (!ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!ready) chk_int("ready_wait_timeout", 0, 1);
        start  = 1'b1;
        c_in   = c;
        r_in   = r;
        rounds = NW'(n);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        job_id++;
        start  = 1'b0;
        c_in   = ~c;
        r_in   = ~r;
        rounds = '1;
    endtask

    task automatic run_job(input logic [CW-1:0] c, input logic [RW-1:0] r, input int n,
                           input logic [CW-1:0] ec, input logic [RW-1:0] er, input logic ee,
                           input int lat, input int pn, input int an);
        int   a;
        exp_t e;
        issue(c, r, n, a);
        e.c        = ec;
        e.r        = er;
        e.e        = ee;
        e.done_cyc = (lat < 0) ? -1 : a + lat;
        e.perm_n   = pn;
        e.acc_n    = an;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            chk_int("job_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [CW-1:0] mc;
        logic [RW-1:0] mr;
        int            a;
        int            k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_int("rst_ready", int'(ready), 1);
        chk_int("rst_done", int'(done), 0);
        chk_int("rst_err", int'(err), 0);
        chk_int("rst_perm_start", int'(perm_start), 0);
        chk_int("rst_acc_start", int'(acc_start), 0);
        chk_vec("rst_c_out", c_out, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero rounds: bypass, done two cycles after start, no engine activity.
        run_job(320'h1, 128'h2, 0, 320'h1, 128'h2, 1'b0, 1, 0, 0);
        wait_idle();

        // Three rounds with one-cycle engines: 17-cycle latency.
        run_job(320'h10, 128'h0, 3, 320'h13, 128'h10, 1'b0, 16, 3, 3);
        wait_idle();

        // Maximum round count: index runs 0..14 without wrapping; XOR of 1..15 is 0.
        run_job(320'h0, 128'h0, 15, 320'hF, 128'h0, 1'b0, 76, 15, 15);
        wait_idle();

        // Random engine delays, carry across the whole capacity word.
        rand_dly = 1'b1;
        mc = {{(CW-4){1'b1}}, 4'h8};
        model(mc, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 10, mc, mr);
        run_job({{(CW-4){1'b1}}, 4'h8}, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 10,
                mc, mr, 1'b0, -1, 10, 10);
        wait_idle();
        rand_dly = 1'b0;

        // Busy start and spurious acc_done during WAIT_PERM are ignored.
        perm_dly = 5;
        run_job(320'h100, 128'h5, 2, 320'h102, 128'h6, 1'b0, 21, 2, 2);
        @(posedge clk);
        #1;
        chk_int("ready_busy", int'(ready), 0);
        start    = 1'b1;
        c_in     = {CW{1'b1}};
        rounds   = 4'd1;
        spur_acc = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        spur_acc = 1'b0;
        wait_idle();
        perm_dly = 0;

        // Silent round engine: watchdog error 64 cycles after entering WAIT_PERM.
        perm_mute = 1'b1;
        run_job(320'hABC, 128'h55, 2, 320'hABC, 128'h55, 1'b1, 65, 1, 0);
        wait_idle();
        perm_mute = 1'b0;

        // Asynchronous reset while waiting on the accumulator.
        acc_dly = 8;
        issue(320'h3, 128'h4, 2, a);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!acc_start && k < 100);
        chk_int("acc_start_seen", int'(acc_start), 1);
        @(posedge clk);
        #1;
        rst_epoch++;
        reset_n = 1'b0;
        #1;
        chk_int("mid_rst_ready", int'(ready), 1);
        chk_int("mid_rst_done", int'(done), 0);
        chk_int("mid_rst_err", int'(err), 0);
        chk_int("mid_rst_acc_start", int'(acc_start), 0);
        chk_int("mid_rst_perm_round", int'(perm_round), 0);
        chk_vec("mid_rst_c_out", c_out, '0);
        chk_vec("mid_rst_r_out", {{(CW-RW){1'b0}}, r_out}, '0);
        chk_vec("mid_rst_acc_c", acc_c, '0);
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc_dly = 0;
        @(posedge clk);
        #1;

        // Clean run after reset.
        run_job(320'h7, 128'h9, 1, 320'h8, 128'h1, 1'b0, 6, 1, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "global timeout");
    end

endmodule
